mem_access_stage: RTL and testbench

//   Memory stage directly downstream of the execute stage. Takes the ALU result (address or value),
//   rs2 store data and control bits; runs load/store transactions on a req/ack data bus with

---
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage: drives a req/ack data bus for loads and stores, formats load data,
// and returns a registered one-cycle writeback bundle. Non-memory ops pass through in one cycle.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic          req_q, we_q, wb_valid_q, wb_we_q, fault_q, regw_q;
  logic [31:0]   addr_q, wdata_q, wb_data_q;
  logic [3:0]    be_q;
  logic [4:0]    wb_rd_q, rd_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;

  logic          illegal_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d, shifted_d, load_data_d;
  logic [1:0]    off_d;

  assign off_d = alu_result[1:0];

  always_comb begin
    illegal_d = 1'b0;
    if (mem_read && mem_write) begin
      illegal_d = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        3'b000, 3'b100: illegal_d = 1'b0;
        3'b001, 3'b101: illegal_d = off_d[0];
        3'b010:         illegal_d = (off_d != 2'b00);
        default:        illegal_d = 1'b1;
      endcase
    end else if (mem_write) begin
      case (funct3)
        3'b000:  illegal_d = 1'b0;
        3'b001:  illegal_d = off_d[0];
        3'b010:  illegal_d = (off_d != 2'b00);
        default: illegal_d = 1'b1;
      endcase
    end
  end

  // Store lanes are replicated so the slave can pick any byte/half lane via be.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'd0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off_d;
          wdata_d = {4{rs2_data[7:0]}};
        end
        2'b01: begin
          be_d    = off_d[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{rs2_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = rs2_data;
        end
      endcase
    end
  end

  always_comb begin
    shifted_d = dbus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b100:  load_data_d = {24'd0, shifted_d[7:0]};
      3'b001:  load_data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b101:  load_data_d = {16'd0, shifted_d[15:0]};
      default: load_data_d = dbus_rdata;
    endcase
  end

  // Ack is checked before the timeout so a late ack on the final cycle still completes normally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= 5'd0;
      regw_q     <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            if (!mem_read && !mem_write) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= reg_write && (rd != 5'd0);
              wb_rd_q    <= rd;
              wb_data_q  <= alu_result;
            end else if (illegal_d) begin
              wb_valid_q <= 1'b1;
              fault_q    <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= rd;
              wb_data_q  <= 32'd0;
            end else begin
              state_q <= BUSY;
              req_q   <= 1'b1;
              we_q    <= mem_write;
              addr_q  <= {alu_result[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              cnt_q   <= '0;
              rd_q    <= rd;
              regw_q  <= reg_write && (rd != 5'd0);
              f3_q    <= funct3;
              off_q   <= off_d;
            end
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_we_q    <= !we_q && regw_q;
            wb_data_q  <= we_q ? 32'd0 : load_data_d;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            fault_q    <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            wb_data_q  <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = (state_q == BUSY);
  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops checked against a
// behavioural model of the memory stage (legality, lanes, load formatting, latency, timeout).
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, reg_write, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result, rs2_data;
  logic        stall, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic        wb_valid, wb_we, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int vectors = 0;
  int errors  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .rd(rd),
    .alu_result(alu_result), .rs2_data(rs2_data), .stall(stall),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  // Observations gathered by run_op; each test compares them itself.
  int          obs_n, obs_req, obs_stall;
  bit          obs_stable, obs_pulse_ok, obs_bwe;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_be;
  logic        obs_we, obs_fault;
  logic [4:0]  obs_rd;

  typedef struct {
    int          n;
    bit          bus;
    bit          fault;
    bit          we;
    logic [31:0] data;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          bwe;
  } exp_t;

  // Reference model: n is the number of negedges after the accept edge until wb_valid is seen.
  function automatic exp_t model_op(input bit mr, input bit mw, input logic [2:0] f3,
                                    input logic [4:0] rdi, input bit regw,
                                    input logic [31:0] addr, input logic [31:0] rs2,
                                    input int delay, input logic [31:0] rdata);
    exp_t e;
    int size, off;
    bit legal;
    longint unsigned mask, val;
    e = '{n: 0, bus: 0, fault: 0, we: 0, data: 32'd0, baddr: 32'd0, be: 4'd0,
          wdata: 32'd0, bwe: 0};
    if (!mr && !mw) begin
      e.we   = regw && (rdi != 0);
      e.data = addr;
      return e;
    end
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    off  = int'(addr % 4);
    legal = !(mr && mw) && size != 0 && (mr ? (f3 != 3'd6 && f3 != 3'd7) : (f3 <= 3'd2))
            && (int'(addr % 32'(size)) == 0);
    if (!legal) begin
      e.fault = 1;
      return e;
    end
    e.bus   = 1;
    e.bwe   = mw;
    e.baddr = addr & ~32'd3;
    if (mw) begin
      e.be    = 4'(((1 << size) - 1) << off);
      e.wdata = (size == 1) ? rs2[7:0] * 32'h0101_0101 :
                (size == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
    end else begin
      e.be = 4'hF;
    end
    if (delay <= TO - 1) begin
      e.n = delay + 1;
      if (mw) begin
        e.we = 0;
        e.data = 0;
      end else begin
        mask = (64'd1 << (8 * size)) - 1;
        val  = (longint'(rdata) >> (8 * off)) & mask;
        if (f3 < 3'd4 && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
        e.data = val[31:0];
        e.we   = regw && (rdi != 0);
      end
    end else begin
      e.n = TO;
      e.fault = 1;
    end
    return e;
  endfunction

  // Issues one instruction at a negedge and acts as the bus slave; records what it saw.
  task automatic run_op(input bit mr, input bit mw, input logic [2:0] f3, input logic [4:0] rdi,
                        input bit regw, input logic [31:0] addr, input logic [31:0] rs2,
                        input int delay, input logic [31:0] rdata);
    valid_in = 1; mem_read = mr; mem_write = mw; funct3 = f3; rd = rdi;
    reg_write = regw; alu_result = addr; rs2_data = rs2;
    dbus_ack = 1'($urandom); dbus_rdata = $urandom;
    @(negedge clk);
    valid_in = 0; dbus_ack = 0; alu_result = $urandom; rs2_data = $urandom; rd = 5'($urandom);
    obs_n = -1; obs_req = 0; obs_stall = 0; obs_stable = 1;
    obs_addr = 'x; obs_be = 'x; obs_wdata = 'x; obs_bwe = 0;
    obs_we = 'x; obs_rd = 'x; obs_data = 'x; obs_fault = 'x;
    for (int k = 0; k < 40; k++) begin
      if (stall === 1'b1) obs_stall++;
      if (dbus_req === 1'b1) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_addr = dbus_addr; obs_be = dbus_be; obs_wdata = dbus_wdata; obs_bwe = dbus_we;
        end else if (dbus_addr !== obs_addr || dbus_be !== obs_be ||
                     dbus_wdata !== obs_wdata || dbus_we !== obs_bwe) begin
          obs_stable = 0;
        end
      end
      if (wb_valid === 1'b1) begin
        obs_n = k; obs_we = wb_we; obs_rd = wb_rd; obs_data = wb_data; obs_fault = fault;
        break;
      end
      dbus_ack   = (k == delay);
      dbus_rdata = (k == delay) ? rdata : $urandom;
      @(negedge clk);
    end
    dbus_ack = 0;
    @(negedge clk);
    obs_pulse_ok = (wb_valid === 1'b0 && fault === 1'b0 && stall === 1'b0);
  endtask

  task automatic test_reset();
    reset = 0; valid_in = 0; reg_write = 0; mem_read = 0; mem_write = 0; funct3 = 0; rd = 0;
    alu_result = 0; rs2_data = 0; dbus_rdata = 0; dbus_ack = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({stall, dbus_req, dbus_we, wb_valid, wb_we, fault} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {stall, dbus_req, dbus_we, wb_valid, wb_we, fault});
    end
    vectors++;
    if (dbus_addr !== 0 || dbus_be !== 0 || dbus_wdata !== 0) begin
      errors++;
      $display("[TB] FAIL reset_bus: addr=%h be=%b wdata=%h want zeros", dbus_addr, dbus_be, dbus_wdata);
    end
    vectors++;
    if (wb_rd !== 0 || wb_data !== 0) begin
      errors++;
      $display("[TB] FAIL reset_wb: rd=%0d data=%h want zeros", wb_rd, wb_data);
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_nonmem();
    run_op(0, 0, 3'd0, 5'd5, 1, 32'h1234, 32'h0, 0, 32'h0);
    vectors++;
    if (obs_n !== 0 || obs_stall !== 0 || obs_req !== 0) begin
      errors++;
      $display("[TB] FAIL nonmem_timing: n=%0d stall=%0d req=%0d want 0/0/0", obs_n, obs_stall, obs_req);
    end
    vectors++;
    if (obs_we !== 1 || obs_rd !== 5 || obs_data !== 32'h1234 || obs_fault !== 0) begin
      errors++;
      $display("[TB] FAIL nonmem_wb: we=%b rd=%0d data=%h fault=%b want 1/5/00001234/0",
               obs_we, obs_rd, obs_data, obs_fault);
    end
    run_op(0, 0, 3'd0, 5'd0, 1, 32'hDEAD_BEEF, 32'h0, 0, 32'h0);
    vectors++;
    if (obs_we !== 0 || obs_data !== 32'hDEAD_BEEF || !obs_pulse_ok) begin
      errors++;
      $display("[TB] FAIL nonmem_rd0: we=%b data=%h pulse=%b want 0/deadbeef/1",
               obs_we, obs_data, obs_pulse_ok);
    end
  endtask

  task automatic test_load_lb();
    run_op(1, 0, 3'd0, 5'd7, 1, 32'h103, 32'h0, 2, 32'h80FF_FFFF);
    vectors++;
    if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_bwe !== 0) begin
      errors++;
      $display("[TB] FAIL lb_bus: addr=%h be=%b we=%b want 00000100/1111/0", obs_addr, obs_be, obs_bwe);
    end
    vectors++;
    if (obs_stall !== 3 || obs_n !== 3 || obs_req !== 3) begin
      errors++;
      $display("[TB] FAIL lb_latency: stall=%0d n=%0d req=%0d want 3/3/3", obs_stall, obs_n, obs_req);
    end
    vectors++;
    if (obs_data !== 32'hFFFF_FF80 || obs_we !== 1 || obs_rd !== 7 || obs_fault !== 0) begin
      errors++;
      $display("[TB] FAIL lb_wb: data=%h we=%b rd=%0d fault=%b want ffffff80/1/7/0",
               obs_data, obs_we, obs_rd, obs_fault);
    end
  endtask

  task automatic test_store_sh();
    run_op(0, 1, 3'd1, 5'd9, 1, 32'h202, 32'hABCD_1234, 0, 32'h0);
    vectors++;
    if (obs_bwe !== 1 || obs_be !== 4'b1100 || obs_wdata !== 32'h1234_1234 || obs_addr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL sh_bus: we=%b be=%b wdata=%h addr=%h want 1/1100/12341234/00000200",
               obs_bwe, obs_be, obs_wdata, obs_addr);
    end
    vectors++;
    if (obs_n !== 1 || obs_we !== 0 || obs_fault !== 0 || obs_data !== 0) begin
      errors++;
      $display("[TB] FAIL sh_wb: n=%0d we=%b fault=%b data=%h want 1/0/0/0", obs_n, obs_we, obs_fault, obs_data);
    end
  endtask

  task automatic test_misaligned();
    run_op(1, 0, 3'd2, 5'd3, 1, 32'h101, 32'h0, 0, 32'h0);
    vectors++;
    if (obs_req !== 0 || obs_n !== 0 || obs_fault !== 1 || obs_we !== 0 || !obs_pulse_ok) begin
      errors++;
      $display("[TB] FAIL lw_misaligned: req=%0d n=%0d fault=%b we=%b pulse=%b want 0/0/1/0/1",
               obs_req, obs_n, obs_fault, obs_we, obs_pulse_ok);
    end
  endtask

  task automatic test_timeout();
    run_op(1, 0, 3'd2, 5'd4, 1, 32'h200, 32'h0, 1000, 32'h0);
    vectors++;
    if (obs_req !== TO || obs_stall !== TO || obs_n !== TO) begin
      errors++;
      $display("[TB] FAIL timeout_len: req=%0d stall=%0d n=%0d want %0d", obs_req, obs_stall, obs_n, TO);
    end
    vectors++;
    if (obs_fault !== 1 || obs_we !== 0 || !obs_pulse_ok) begin
      errors++;
      $display("[TB] FAIL timeout_wb: fault=%b we=%b pulse=%b want 1/0/1", obs_fault, obs_we, obs_pulse_ok);
    end
    run_op(1, 0, 3'd2, 5'd4, 1, 32'h200, 32'h0, TO - 1, 32'h5555_AAAA);
    vectors++;
    if (obs_fault !== 0 || obs_n !== TO || obs_data !== 32'h5555_AAAA) begin
      errors++;
      $display("[TB] FAIL ack_at_timeout: fault=%b n=%0d data=%h want 0/%0d/5555aaaa",
               obs_fault, obs_n, obs_data, TO);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    valid_in = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; rd = 5'd6; reg_write = 1;
    alu_result = 32'h400;
    @(negedge clk);
    valid_in = 0;
    vectors++;
    if (dbus_req !== 1) begin
      errors++;
      $display("[TB] FAIL midop_req: got %b want 1", dbus_req);
    end
    reset = 0;
    @(negedge clk);
    vectors++;
    if (dbus_req !== 0 || stall !== 0 || wb_valid !== 0) begin
      errors++;
      $display("[TB] FAIL midop_abort: req=%b stall=%b wbv=%b want 0/0/0", dbus_req, stall, wb_valid);
    end
    reset = 1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      dbus_ack = 1;
      @(negedge clk);
      if (wb_valid === 1'b1) pulses++;
    end
    dbus_ack = 0;
    vectors++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL midop_no_wb: got %0d pulses want 0", pulses);
    end
    run_op(1, 0, 3'd4, 5'd8, 1, 32'h301, 32'h0, 1, 32'h1234_5678);
    vectors++;
    if (obs_n !== 2 || obs_data !== 32'h56 || obs_we !== 1 || obs_fault !== 0) begin
      errors++;
      $display("[TB] FAIL after_reset_lbu: n=%0d data=%h we=%b fault=%b want 2/00000056/1/0",
               obs_n, obs_data, obs_we, obs_fault);
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit mr, mw, regw;
    logic [2:0] f3;
    logic [4:0] rdi;
    logic [31:0] addr, rs2, rdata;
    int delay, kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      mr = (kind >= 2 && kind <= 5) || kind == 9;
      mw = kind >= 6;
      f3 = 3'($urandom);
      if ($urandom_range(0, 2) != 0) f3 = mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      rdi = 5'($urandom); regw = 1'($urandom);
      addr = $urandom; rs2 = $urandom; rdata = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = (f3[1:0] == 2'd1) ? 2'($urandom_range(0, 1) * 2) : 2'd0;
      delay = $urandom_range(0, TO + 1);
      e = model_op(mr, mw, f3, rdi, regw, addr, rs2, delay, rdata);
      run_op(mr, mw, f3, rdi, regw, addr, rs2, delay, rdata);
      vectors++;
      if (obs_n !== e.n || obs_req !== (e.bus ? e.n : 0) || obs_stall !== (e.bus ? e.n : 0)) begin
        errors++;
        $display("[TB] FAIL rand%0d_timing: n=%0d req=%0d stall=%0d want n=%0d bus=%b",
                 i, obs_n, obs_req, obs_stall, e.n, e.bus);
      end
      vectors++;
      if (obs_fault !== e.fault || obs_we !== e.we || obs_rd !== rdi || !obs_pulse_ok ||
          (!e.fault && obs_data !== e.data)) begin
        errors++;
        $display("[TB] FAIL rand%0d_wb: fault=%b we=%b rd=%0d data=%h pulse=%b want %b/%b/%0d/%h/1",
                 i, obs_fault, obs_we, obs_rd, obs_data, obs_pulse_ok, e.fault, e.we, rdi, e.data);
      end
      if (e.bus) begin
        vectors++;
        if (obs_addr !== e.baddr || obs_be !== e.be || obs_bwe !== e.bwe || !obs_stable ||
            (e.bwe && obs_wdata !== e.wdata)) begin
          errors++;
          $display("[TB] FAIL rand%0d_bus: addr=%h be=%b we=%b wdata=%h stable=%b want %h/%b/%b/%h/1",
                   i, obs_addr, obs_be, obs_bwe, obs_wdata, obs_stable, e.baddr, e.be, e.bwe, e.wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_lb();
    test_store_sh();
    test_misaligned();
    test_timeout();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
